// File: rtl/node_port_arbiter.sv
// Burst-holding two-requester arbiter onto the avm_node master; command 1 cycle after request, readdata 0 cycles.
// Requester waitrequest follows avm_node_waitrequest only while granted and commanding; NODE_ARB_FIXED_PRIO_EN gives rq0 tie priority.
module node_port_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int BURST_W = 6
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [ADDR_W-1:0]  avs_rq0_address,
    input  logic               avs_rq0_read,
    input  logic               avs_rq0_write,
    input  logic [DATA_W-1:0]  avs_rq0_writedata,
    input  logic [BURST_W-1:0] avs_rq0_burstcount,
    output logic               avs_rq0_waitrequest,
    output logic [DATA_W-1:0]  avs_rq0_readdata,
    output logic               avs_rq0_readdatavalid,

    input  logic [ADDR_W-1:0]  avs_rq1_address,
    input  logic               avs_rq1_read,
    input  logic               avs_rq1_write,
    input  logic [DATA_W-1:0]  avs_rq1_writedata,
    input  logic [BURST_W-1:0] avs_rq1_burstcount,
    output logic               avs_rq1_waitrequest,
    output logic [DATA_W-1:0]  avs_rq1_readdata,
    output logic               avs_rq1_readdatavalid,

    output logic [ADDR_W-1:0]  avm_node_address,
    output logic               avm_node_read,
    output logic               avm_node_write,
    output logic [DATA_W-1:0]  avm_node_writedata,
    output logic [BURST_W-1:0] avm_node_burstcount,
    input  logic [DATA_W-1:0]  avm_node_readdata,
    input  logic               avm_node_readdatavalid,
    input  logic               avm_node_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_CMD  = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q,  last_d;
    logic [BURST_W-1:0] beats_q, beats_d;

    logic               req0, req1, tie_winner, winner, win_write;
    logic               sel_read, sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BURST_W-1:0] sel_bc, sel_bc_eff;
    logic               cmd_phase;

    assign req0 = avs_rq0_read | avs_rq0_write;
    assign req1 = avs_rq1_read | avs_rq1_write;

`ifdef NODE_ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    assign tie_winner = ~last_q;
`endif

    assign winner    = req0 ? (req1 ? tie_winner : 1'b0) : 1'b1;
    assign win_write = winner ? avs_rq1_write : avs_rq0_write;

    assign sel_read   = grant_q ? avs_rq1_read       : avs_rq0_read;
    assign sel_write  = grant_q ? avs_rq1_write      : avs_rq0_write;
    assign sel_addr   = grant_q ? avs_rq1_address    : avs_rq0_address;
    assign sel_wdata  = grant_q ? avs_rq1_writedata  : avs_rq0_writedata;
    assign sel_bc     = grant_q ? avs_rq1_burstcount : avs_rq0_burstcount;
    assign sel_bc_eff = (sel_bc == '0) ? BURST_W'(1) : sel_bc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // In WR, beats_q == 0 marks "first beat not yet taken"; the count is loaded on that beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beats_d = beats_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d = winner;
                    last_d  = winner;
                    beats_d = '0;
                    state_d = win_write ? S_WR : S_RD_CMD;
                end
            end
            S_WR: begin
                if (sel_write && !avm_node_waitrequest) begin
                    if (beats_q == '0) begin
                        if (sel_bc_eff == BURST_W'(1)) state_d = S_IDLE;
                        else                           beats_d = sel_bc_eff - BURST_W'(1);
                    end else begin
                        beats_d = beats_q - BURST_W'(1);
                        if (beats_q == BURST_W'(1)) state_d = S_IDLE;
                    end
                end
            end
            S_RD_CMD: begin
                if (!avm_node_waitrequest) begin
                    beats_d = sel_bc_eff;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (avm_node_readdatavalid) begin
                    beats_d = beats_q - BURST_W'(1);
                    if (beats_q == BURST_W'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_phase           = (state_q == S_WR) || (state_q == S_RD_CMD);
        avm_node_address    = '0;
        avm_node_read       = 1'b0;
        avm_node_write      = 1'b0;
        avm_node_writedata  = '0;
        avm_node_burstcount = '0;
        if (cmd_phase) begin
            avm_node_address    = sel_addr;
            avm_node_writedata  = sel_wdata;
            avm_node_burstcount = sel_bc;
            avm_node_read       = (state_q == S_RD_CMD) && sel_read;
            avm_node_write      = (state_q == S_WR) && sel_write;
        end
        avs_rq0_waitrequest   = (cmd_phase && !grant_q) ? avm_node_waitrequest : 1'b1;
        avs_rq1_waitrequest   = (cmd_phase &&  grant_q) ? avm_node_waitrequest : 1'b1;
        avs_rq0_readdatavalid = (state_q == S_RD_DATA) && !grant_q && avm_node_readdatavalid;
        avs_rq1_readdatavalid = (state_q == S_RD_DATA) &&  grant_q && avm_node_readdatavalid;
    end

    assign avs_rq0_readdata = avm_node_readdata;
    assign avs_rq1_readdata = avm_node_readdata;

endmodule
